// File: rtl/booth_pp_sequencer_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth partial-product sequencer.
package booth_pp_sequencer_pkg;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_e;

  typedef enum logic {IDLE, EMIT} state_e;

  function automatic int N(input int width);
    return width / 2 + 1;
  endfunction

  function automatic int BEATS(input int width);
    return (N(width) + 7) / 8;
  endfunction

  function automatic booth_digit_e booth_decode(input logic [2:0] t);
    case (t)
      3'b001, 3'b010: return POS1;
      3'b011:         return POS2;
      3'b100:         return NEG2;
      3'b101, 3'b110: return NEG1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_enc_sel.sv
// One radix-4 Booth digit: select 0/+-X/+-2X from a bit triple, then pre-shift to its weight.
module booth_enc_sel
  import booth_pp_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int PW = 2 * WIDTH,
  localparam int SHW = $clog2(PW)
) (
  input  logic [2:0]           triple,
  input  logic signed [PW-1:0] x,
  input  logic [SHW-1:0]       shamt,
  output logic [PW-1:0]        pp
);

  booth_digit_e        digit;
  logic signed [PW-1:0] mag;
  logic signed [PW-1:0] val;

  always_comb begin
    digit = booth_decode(triple);
    mag   = '0;
    case (digit)
      POS1, NEG1: mag = x;
      POS2, NEG2: mag = x <<< 1;
      default:    mag = '0;
    endcase
    // Full two's complement negation; no separate correction bits downstream.
    val = (digit == NEG1 || digit == NEG2) ? ~mag + PW'(1) : mag;
    pp  = val << shamt;
  end

endmodule

// File: rtl/booth_pp_sequencer.sv
// Sequential radix-4 Booth partial-product generator: one operation per handshake,
// eight pre-shifted, sign-correct partial products per beat.
module booth_pp_sequencer
  import booth_pp_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  input  logic                 in_signed,
  output logic                 pp_valid,
  input  logic                 pp_ready,
  output logic [2*WIDTH-1:0]   pp [8],
  output logic                 pp_first,
  output logic                 pp_last
);

  localparam int PW     = 2 * WIDTH;
  localparam int NPP    = N(WIDTH);
  localparam int NBEATS = BEATS(WIDTH);
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int SHW    = $clog2(PW);
  localparam int IW     = $clog2(WIDTH + 3);
  localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

  state_e               state;
  logic [CW-1:0]        cnt;
  logic signed [PW-1:0] x_p0;
  logic [WIDTH+1:0]     y_p0;
  logic [WIDTH+2:0]     y_ext;
  logic [2:0]           triple [8];
  logic [SHW-1:0]       shamt [8];
  logic                 live [8];
  logic [PW-1:0]        pp_raw [8];

  // Operand capture: extended once at acceptance, held for the whole operation.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      x_p0 <= in_signed ? {{WIDTH{in_x[WIDTH-1]}}, in_x} : {{WIDTH{1'b0}}, in_x};
      y_p0 <= in_signed ? {{2{in_y[WIDTH-1]}}, in_y} : {2'b00, in_y};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      in_ready <= 1'b1;
      pp_valid <= 1'b0;
      pp_first <= 1'b0;
      pp_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= EMIT;
            cnt      <= '0;
            in_ready <= 1'b0;
            pp_valid <= 1'b1;
            pp_first <= 1'b1;
            pp_last  <= (NBEATS == 1);
          end
        end
        EMIT: begin
          if (pp_ready) begin
            if (cnt == LAST) begin
              state    <= IDLE;
              in_ready <= 1'b1;
              pp_valid <= 1'b0;
              pp_first <= 1'b0;
              pp_last  <= 1'b0;
            end else begin
              cnt      <= cnt + CW'(1);
              pp_first <= 1'b0;
              pp_last  <= ((cnt + CW'(1)) == LAST);
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          pp_valid <= 1'b0;
          pp_first <= 1'b0;
          pp_last  <= 1'b0;
        end
      endcase
    end
  end

  // y[-1] = 0 sits below bit 0, so triple i is y_ext[2i+2:2i].
  assign y_ext = {y_p0, 1'b0};

  always_comb begin
    for (int s = 0; s < 8; s++) begin
      int               idx;
      logic [WIDTH+2:0] win;
      idx       = int'(cnt) * 8 + s;
      live[s]   = (idx < NPP);
      triple[s] = '0;
      shamt[s]  = '0;
      win       = '0;
      if (live[s]) begin
        win       = y_ext >> IW'(2 * idx);
        triple[s] = win[2:0];
        shamt[s]  = SHW'(2 * idx);
      end
    end
  end

  for (genvar s = 0; s < 8; s++) begin : g_slot
    booth_enc_sel #(.WIDTH(WIDTH)) u_enc (
      .triple (triple[s]),
      .x      (x_p0),
      .shamt  (shamt[s]),
      .pp     (pp_raw[s])
    );
  end

  always_comb begin
    for (int s = 0; s < 8; s++) begin
      pp[s] = (pp_valid && live[s]) ? pp_raw[s] : '0;
    end
  end

endmodule

// File: tb/tb_booth_pp_sequencer.sv
// Scoreboard bench for booth_pp_sequencer at WIDTH=32 (17 partial products, 3 beats).
module tb_booth_pp_sequencer;

  localparam int W     = 32;
  localparam int NB    = 3;

  typedef struct packed {
    logic [63:0]        prod;
    logic               chk;
    logic [23:0][63:0]  w;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic        in_signed;
  logic        pp_valid;
  logic        pp_ready;
  logic [63:0] pp [8];
  logic        pp_first;
  logic        pp_last;

  exp_t exp_q [$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   ready_mode = 0;
  logic ready_manual = 1'b1;
  bit   mon_busy = 0;

  booth_pp_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_signed (in_signed),
    .pp_valid  (pp_valid),
    .pp_ready  (pp_ready),
    .pp        (pp),
    .pp_first  (pp_first),
    .pp_last   (pp_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t e;
    e = '0;
    if (s) e.prod = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
    else   e.prod = {32'b0, x} * {32'b0, y};
    return e;
  endfunction

  function automatic bit all_zero();
    for (int s = 0; s < 8; s++) if (pp[s] != 64'd0) return 0;
    return 1;
  endfunction

  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic s, input exp_t e);
    in_x = x; in_y = y; in_signed = s; in_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready && rstn) begin
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check(0, "accept_timeout", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
  endtask

  // pp_ready driver: always ready, random, or a manually set level.
  initial begin
    pp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0)      pp_ready = 1'b1;
      else if (ready_mode == 1) pp_ready = ($urandom_range(0, 3) != 0);
      else                      pp_ready = ready_manual;
    end
  end

  // Monitor: accumulates handshaken beats and compares against the queued expectation.
  initial begin
    int          beat;
    logic [63:0] sum;
    exp_t        cur;
    beat = 0; sum = '0; cur = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        beat = 0; sum = '0; mon_busy = 0;
        exp_q.delete();
        continue;
      end
      if (!pp_valid) begin
        check(!pp_first && !pp_last && all_zero(), "idle_outputs", {62'd0, pp_first, pp_last}, 64'd0);
        continue;
      end
      if (!pp_ready) continue;
      if (beat == 0) begin
        if (exp_q.size() == 0) begin
          check(0, "unexpected_beat", 64'd1, 64'd0);
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
        end
        sum = '0;
        mon_busy = 1;
      end
      check(pp_first == (beat == 0), "pp_first", {63'd0, pp_first}, {63'd0, beat == 0});
      check(pp_last == (beat == NB - 1), "pp_last", {63'd0, pp_last}, {63'd0, beat == NB - 1});
      if (cur.chk) begin
        bit ok;
        int bad;
        ok = 1; bad = 0;
        for (int s = 0; s < 8; s++) begin
          if (ok && pp[s] != cur.w[beat * 8 + s]) begin ok = 0; bad = s; end
        end
        check(ok, $sformatf("words_beat%0d_slot%0d", beat, bad), pp[bad], cur.w[beat * 8 + bad]);
      end
      for (int s = 0; s < 8; s++) sum += pp[s];
      if (beat == NB - 1) begin
        bit z;
        z = 1;
        for (int s = 1; s < 8; s++) if (pp[s] != 64'd0) z = 0;
        check(z, "last_beat_tail_zero", pp[1] | pp[7], 64'd0);
        check(sum == cur.prod, "product_sum", sum, cur.prod);
        beat = 0;
        mon_busy = 0;
      end else begin
        beat++;
      end
    end
  end

  initial begin
    exp_t        e;
    logic [63:0] snap [8];
    logic        sf, sl;
    bit          same;
    bit          drained;

    rstn = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_signed = 1'b0;
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    check(in_ready == 1'b1, "reset_in_ready", {63'd0, in_ready}, 64'd1);
    check(pp_valid == 1'b0, "reset_pp_valid", {63'd0, pp_valid}, 64'd0);
    check(!pp_first && !pp_last, "reset_flags", {62'd0, pp_first, pp_last}, 64'd0);
    check(all_zero(), "reset_pp_zero", pp[0], 64'd0);
    @(posedge clk); #1 rstn = 1'b1;

    // Signed 3 x 5: +X at weight 0 and weight 4.
    ready_mode = 0;
    e = mk(32'd3, 32'd5, 1'b1); e.chk = 1; e.w[0] = 64'd3; e.w[1] = 64'd12;
    do_op(32'd3, 32'd5, 1'b1, e);

    // Signed -1 x -1: only PP0 = -X = 1.
    e = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); e.chk = 1; e.w[0] = 64'd1;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, e);

    // Unsigned max x max: PP0 = -X, PP16 = +X << 32.
    e = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); e.chk = 1;
    e.w[0] = 64'hFFFF_FFFF_0000_0001; e.w[16] = 64'hFFFF_FFFF_0000_0000;
    check(e.prod == 64'hFFFF_FFFE_0000_0001, "ref_unsigned_max", e.prod, 64'hFFFF_FFFE_0000_0001);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, e);

    // Backpressure on beat 1 with a pending request held on the input.
    ready_mode = 2; ready_manual = 1'b1;
    @(posedge clk); #2;
    e = mk(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, e);
    ready_manual = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 8; s++) snap[s] = pp[s];
    sf = pp_first; sl = pp_last;
    check(pp_valid && !sf && !sl, "stall_beat1_flags", {61'd0, pp_valid, sf, sl}, 64'd4);
    in_x = 32'd3; in_y = 32'd5; in_signed = 1'b1; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      same = (pp_first == sf) && (pp_last == sl) && pp_valid;
      for (int s = 0; s < 8; s++) if (pp[s] != snap[s]) same = 0;
      check(same, "stall_hold", pp[0], snap[0]);
      check(in_ready == 1'b0, "stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    ready_manual = 1'b1;
    e = mk(32'd3, 32'd5, 1'b1); e.chk = 1; e.w[0] = 64'd3; e.w[1] = 64'd12;
    do_op(32'd3, 32'd5, 1'b1, e);

    // Reset during beat 1, then signed 7 x -2 (PP0 = -2X = -14).
    ready_mode = 0;
    repeat (4) @(posedge clk);
    #2;
    e = mk(32'd9, 32'd11, 1'b0);
    do_op(32'd9, 32'd11, 1'b0, e);
    @(posedge clk); #2 rstn = 1'b0;
    @(negedge clk);
    check(pp_valid == 1'b0, "midreset_pp_valid", {63'd0, pp_valid}, 64'd0);
    check(in_ready == 1'b1, "midreset_in_ready", {63'd0, in_ready}, 64'd1);
    check(all_zero() && !pp_first && !pp_last, "midreset_outputs", pp[0], 64'd0);
    @(posedge clk); #1 rstn = 1'b1;
    e = mk(32'd7, 32'hFFFF_FFFE, 1'b1); e.chk = 1; e.w[0] = 64'hFFFF_FFFF_FFFF_FFF2;
    check(e.prod == 64'hFFFF_FFFF_FFFF_FFF2, "ref_7x_neg2", e.prod, 64'hFFFF_FFFF_FFFF_FFF2);
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, e);

    // Random operands and random downstream backpressure.
    ready_mode = 1;
    for (int k = 0; k < 4000; k++) begin
      logic [31:0] rx, ry;
      logic        rs;
      rx = $urandom; ry = $urandom; rs = 1'($urandom_range(0, 1));
      if (k % 50 == 0) rx = 32'h8000_0000;
      if (k % 70 == 0) ry = 32'h7FFF_FFFF;
      e = mk(rx, ry, rs);
      do_op(rx, ry, rs, e);
    end

    ready_mode = 0;
    drained = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_busy) begin drained = 1; break; end
    end
    check(drained, "drain_timeout", {32'd0, 32'(exp_q.size())}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
